// File: rtl/rf_pkg.sv
// Shared helpers for the register-file scoreboard: depth limits, busy-vector popcount
// and slice macros for the flattened multi-port buses.
`ifndef RF_PKG_SV
`define RF_PKG_SV

`define RF_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package rf_pkg;

    localparam int ADDR_W_MAX = 8;
    localparam int DEPTH_MAX  = 2**ADDR_W_MAX;
    localparam int DEPTH      = 2**5;

    function automatic int depthOf(input int addrW);
        return 2**addrW;
    endfunction

    // Callers zero-extend their busy vector to DEPTH_MAX bits.
    function automatic logic [ADDR_W_MAX:0] popcount(input logic [DEPTH_MAX-1:0] v);
        logic [ADDR_W_MAX:0] n;
        n = '0;
        for (int i = 0; i < DEPTH_MAX; i++)
            n = n + {{ADDR_W_MAX{1'b0}}, v[i]};
        return n;
    endfunction

endpackage

`endif

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register override, write bypass, busy masking.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regData,
    input  logic              busyBit,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic isZero;
    logic hit;

    assign isZero = (ZERO_REG != 0) && (addr == '0);
    assign hit    = (BYPASS != 0) && writeEnable && (writeReg == addr);

    always_comb begin
        data = regData;
        busy = busyBit;
        if (isZero) begin
            data = '0;
            busy = 1'b0;
        end else if (hit) begin
            data = writeData;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy scoreboard, reserve/ack issue handshake and flush.
module reg_file_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_READ*ADDR_W-1:0] readAddr,
    output logic [N_READ*DATA_W-1:0] readData,
    output logic [N_READ-1:0]        readBusy,
    input  logic                     writeEnable,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     reserveEnable,
    input  logic [ADDR_W-1:0]        reserveReg,
    output logic                     reserveAck,
    input  logic                     flush,
    output logic [ADDR_W:0]          busyCount
);

    localparam int NREGS = depthOf(ADDR_W);

    logic [DATA_W-1:0]    regs [NREGS];
    logic [NREGS-1:0]     busy;
    logic [NREGS-1:0]     effBusy;
    logic [NREGS-1:0]     busyNext;
    logic [DEPTH_MAX-1:0] busyWide;
    logic                 writeZero;

    assign writeZero = (ZERO_REG != 0) && (writeReg == '0);

    // A write in flight releases its register for this cycle's consumers and issuers.
    always_comb begin
        for (int r = 0; r < NREGS; r++)
            effBusy[r] = busy[r] && !((BYPASS != 0) && writeEnable && (writeReg == ADDR_W'(r)));
        if (ZERO_REG != 0)
            effBusy[0] = 1'b0;
    end

    assign reserveAck = reserveEnable && !flush && !effBusy[reserveReg];

    // Order matters: write clears, then a granted reserve re-marks the same register.
    always_comb begin
        busyNext = busy;
        if (writeEnable)
            busyNext[writeReg] = 1'b0;
        if (flush)
            busyNext = '0;
        else if (reserveAck)
            busyNext[reserveReg] = 1'b1;
        if (ZERO_REG != 0)
            busyNext[0] = 1'b0;
    end

    always_comb begin
        busyWide = '0;
        busyWide[NREGS-1:0] = busyNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            busy      <= '0;
            busyCount <= '0;
        end else begin
            if (writeEnable && !writeZero)
                regs[writeReg] <= writeData;
            busy      <= busyNext;
            busyCount <= (ADDR_W+1)'(popcount(busyWide));
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : gRead
        logic [ADDR_W-1:0] a;
        assign a = `RF_SLICE(readAddr, k, ADDR_W);

        rf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) uPort (
            .addr       (a),
            .regData    (regs[a]),
            .busyBit    (busy[a]),
            .writeEnable(writeEnable),
            .writeReg   (writeReg),
            .writeData  (writeData),
            .data       (`RF_SLICE(readData, k, DATA_W)),
            .busy       (readBusy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomized and directed self-checking bench for reg_file_scoreboard against an array model.
module tb_reg_file_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int ND = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR*AW-1:0] readAddr;
    logic [NR*DW-1:0] readData;
    logic [NR-1:0] readBusy;
    logic          writeEnable;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic          reserveEnable;
    logic [AW-1:0] reserveReg;
    logic          reserveAck;
    logic          flush;
    logic [AW:0]   busyCount;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mRegs [ND];
    bit            mBusy [ND];

    reg_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .readAddr(readAddr), .readData(readData), .readBusy(readBusy),
        .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData),
        .reserveEnable(reserveEnable), .reserveReg(reserveReg), .reserveAck(reserveAck),
        .flush(flush), .busyCount(busyCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] portData(input int k);
        return readData[k*DW +: DW];
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int r = 0; r < ND; r++) n += int'(mBusy[r]);
        return n;
    endfunction

    function automatic logic [DW-1:0] expRead(input int a);
        if (a == 0) return '0;
        if (writeEnable && int'(writeReg) == a) return writeData;
        return mRegs[a];
    endfunction

    function automatic bit expBusy(input int a);
        if (a == 0) return 1'b0;
        if (writeEnable && int'(writeReg) == a) return 1'b0;
        return mBusy[a];
    endfunction

    task automatic modelReset();
        for (int r = 0; r < ND; r++) begin
            mRegs[r] = '0;
            mBusy[r] = 1'b0;
        end
    endtask

    task automatic setRead(input int a0, input int a1);
        readAddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        writeEnable = 0; reserveEnable = 0; flush = 0;
    endtask

    // Checks outputs against the model before the edge, advances the model, checks busyCount after.
    task automatic cycle(input string tag);
        bit ack;
        #1;
        for (int k = 0; k < NR; k++) begin
            int a = int'(readAddr[k*AW +: AW]);
            chk({tag, ".data"}, portData(k), expRead(a));
            chk({tag, ".busy"}, readBusy[k], expBusy(a));
        end
        ack = reserveEnable && !flush && !expBusy(int'(reserveReg));
        chk({tag, ".ack"}, reserveAck, ack);
        if (writeEnable && writeReg != 0) mRegs[writeReg] = writeData;
        if (writeEnable) mBusy[writeReg] = 1'b0;
        if (flush) for (int r = 0; r < ND; r++) mBusy[r] = 1'b0;
        else if (ack && reserveReg != 0) mBusy[reserveReg] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".cnt"}, busyCount, modelCount());
    endtask

    initial begin
        reset = 1; idle(); writeReg = 0; writeData = 0; reserveReg = 0; readAddr = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 chk("rst.cnt", busyCount, 0);
        chk("rst.data0", portData(0), 0);
        reset = 0;

        // write/readback with same-cycle bypass
        writeEnable = 1; writeReg = 5; writeData = 32'hDEADBEEF; setRead(5, 5);
        #1 chk("wr.bypass", portData(0), 32'hDEADBEEF);
        cycle("wr");
        idle();
        #1 chk("wr.rd0", portData(0), 32'hDEADBEEF);
        chk("wr.rd1", portData(1), 32'hDEADBEEF);
        cycle("wr2");

        // zero register
        writeEnable = 1; writeReg = 0; writeData = 32'h1234;
        reserveEnable = 1; reserveReg = 0; setRead(0, 5);
        #1 chk("z.ack", reserveAck, 1);
        cycle("z");
        idle();
        #1 chk("z.rd", portData(0), 0);
        chk("z.busy", readBusy[0], 0);
        chk("z.cnt", busyCount, 0);

        // scoreboard reserve / deny / release
        reserveEnable = 1; reserveReg = 3; setRead(3, 5);
        #1 chk("sb.ack1", reserveAck, 1);
        cycle("sb1");
        #1 chk("sb.ack2", reserveAck, 0);
        cycle("sb2");
        chk("sb.cnt", busyCount, 1);
        reserveEnable = 0; writeEnable = 1; writeReg = 3; writeData = 32'h33;
        cycle("sb3");
        idle(); reserveEnable = 1; reserveReg = 3;
        #1 chk("sb.ack3", reserveAck, 1);
        cycle("sb4");

        // same-edge write and reserve of busy r7
        idle(); reserveEnable = 1; reserveReg = 7; setRead(7, 3);
        cycle("r7a");
        writeEnable = 1; writeReg = 7; writeData = 32'hCAFE0007;
        #1 chk("r7.busy", readBusy[0], 0);
        chk("r7.ack", reserveAck, 1);
        cycle("r7b");
        idle();
        #1 chk("r7.data", portData(0), 32'hCAFE0007);
        chk("r7.busyAfter", readBusy[0], 1);

        // flush beats reserve, data kept
        flush = 1; cycle("fl0"); flush = 0;
        reserveEnable = 1;
        reserveReg = 1; cycle("f1");
        reserveReg = 2; cycle("f2");
        reserveReg = 4; cycle("f4");
        chk("fl.cnt3", busyCount, 3);
        reserveReg = 9; flush = 1; setRead(5, 7);
        #1 chk("fl.ack", reserveAck, 0);
        cycle("fl");
        idle();
        #1 chk("fl.cnt0", busyCount, 0);
        chk("fl.keep5", portData(0), 32'hDEADBEEF);
        chk("fl.keep7", portData(1), 32'hCAFE0007);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            writeEnable   = ($urandom_range(0, 1) == 1);
            writeReg      = AW'($urandom_range(0, 15));
            writeData     = $urandom;
            reserveEnable = ($urandom_range(0, 2) != 0);
            reserveReg    = AW'($urandom_range(0, 15));
            flush         = ($urandom_range(0, 31) == 0);
            setRead($urandom_range(0, 15), $urandom_range(0, 15));
            cycle("rnd");
        end

        // asynchronous reset between edges
        idle(); reserveEnable = 1; reserveReg = 6; setRead(5, 7);
        #2 reset = 1;
        #1 chk("arst.rd0", portData(0), 0);
        chk("arst.rd1", portData(1), 0);
        chk("arst.busy", readBusy, 0);
        chk("arst.cnt", busyCount, 0);
        chk("arst.ack", reserveAck, 1);
        modelReset();
        @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 50; i++) begin
            writeEnable   = ($urandom_range(0, 1) == 1);
            writeReg      = AW'($urandom);
            writeData     = $urandom;
            reserveEnable = ($urandom_range(0, 1) == 1);
            reserveReg    = AW'($urandom);
            flush         = 0;
            setRead($urandom_range(0, 31), $urandom_range(0, 31));
            cycle("post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
